int_sequencer: RTL and testbench
================================

INT_SEQUENCER -- requirements
Module: int_sequencer

Interface
REQ-001 SHALL: VEC_BASE0, 11'd0, vector word address for INT0 (hi at base, lo at base+1).
REQ-002 SHALL: VEC_BASE1, 11'd2, vector word address for INT1 (hi at base, lo at base+1).
REQ-003 SHALL: clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL: reset  in  1  synchronous, active-high.
REQ-005 SHALL: interruptSignal  in  2  interrupt lines; bit0 = INT0 (high priority), bit1 = INT1.
REQ-006 SHALL: instrBoundary  in  1  processor at a safe point (pipeline drained); service may start.
REQ-007 SHALL: retPc  in  32  return PC to save.
REQ-008 SHALL: spIn  in  11  current stack pointer (word address; stack grows down).
REQ-009 SHALL: cpuMemRead, cpuMemWrite  in  1 each  processor data-memory requests.
REQ-010 SHALL: cpuAddr  in  11 / cpuWrData  in  16  processor address and write data.
REQ-011 SHALL: memRdData  in  16  data-memory read data, combinational, same cycle as address.
REQ-012 SHALL: memRead, memWrite  out  1 each / memAddr  out  11 / memWrData  out  16  data-memory port.
REQ-013 SHALL: stall  out  1  freezes processor PC and pipeline registers.
REQ-014 SHALL: pcLoad  out  1 / pcNew  out  32  one-cycle PC load with ISR address.
REQ-015 SHALL: spLoad  out  1 / spNew  out  11  one-cycle stack-pointer update.
REQ-016 SHALL: intAck  out  2  one-cycle one-hot acknowledge of the serviced line.

Function
REQ-017 SHALL: a 0->1 transition on interruptSignal[i] (registered previous value) sets pending[i]; level held high does not re-set it.
REQ-018 SHALL: pending[i] clears only in LOAD for the serviced line; an edge on that line in the same cycle as its clear leaves pending[i] set (set wins).
REQ-019 SHALL: FSM states IDLE, PUSH_HI, PUSH_LO, VEC_HI, VEC_LO, LOAD.
REQ-020 SHALL: IDLE -> PUSH_HI when any pending and instrBoundary=1; the serviced line is latched then (INT0 wins if both pending), and spIn is latched as sp.
REQ-021 SHALL: PUSH_HI writes retPc[31:16] to sp; PUSH_LO writes retPc[15:0] to sp-1; retPc is latched on IDLE exit.
REQ-022 SHALL: VEC_HI reads base, captures memRdData as pcNew[31:16]; VEC_LO reads base+1, captures pcNew[15:0].
REQ-023 SHALL: LOAD asserts pcLoad, spLoad with spNew = sp-2, and intAck for the serviced line, all for exactly one cycle, then returns to IDLE.
REQ-024 SHALL: service latency from IDLE-exit edge to pcLoad = 5 cycles; no other state lingers.
REQ-025 SHALL: stall = 1 in every state except IDLE.
REQ-026 SHALL: in IDLE, the memory port passes cpu signals through combinationally; outside IDLE, cpu requests are ignored (not queued).
REQ-027 SHALL: sp arithmetic is modulo 2048 (sp=0 pushes to 0 and 2047; spNew=2046).
REQ-028 SHALL: an edge on INT0 during INT1 service does not preempt; it is served next, starting directly from IDLE when instrBoundary=1.
REQ-029 SHALL: memRead and memWrite are never both 1.

Reset
REQ-030 SHALL: on reset, state=IDLE, pending=0, edge history=0, and pcLoad, spLoad, intAck, stall, memRead, memWrite, pcNew, spNew = 0.
REQ-031 SHALL: reset during service abandons it without further memory writes; the interrupt is lost.

Structure
REQ-032 SHALL: FSM state enum, VEC_BASE defaults and the return-PC word count (2) live in the shared processor package.
REQ-033 SHALL: edge detect and the pending latch form one sub-module int_pending (2 lines, priority-encoded select output).

Verification
REQ-034 SHALL: INT0 edge, instrBoundary=1, sp=100, retPc=0x0001_0040, mem[0..1]=0x0002,0x0300 -> writes 0x0001@100, 0x0040@99; pcNew=0x0002_0300, spNew=98, intAck=01, 5 cycles after IDLE exit.
REQ-035 SHALL: INT0 and INT1 edges in the same cycle -> INT0 served (intAck=01), then INT1 (intAck=10), vectors 0/1 then 2/3.
REQ-036 SHALL: INT1 pending, instrBoundary=0 for 10 cycles -> stall=0, cpu writes pass through; service starts after instrBoundary rises.
REQ-037 SHALL: sp=0 -> writes to addresses 0 and 2047, spNew=2046.
REQ-038 SHALL: reset asserted in PUSH_LO -> next cycle IDLE, memWrite=0, pending=00, no pcLoad.
REQ-039 SHALL: interruptSignal[0] held high 20 cycles -> exactly one service and one intAck.

Source files
------------

// File: rtl/int_sequencer_pkg.sv
// Shared definitions for the interrupt entry sequencer: state codes,
// default vector table addresses and the size of the saved return PC.
package int_sequencer_pkg;

    // Return PC is pushed as two 16-bit words (hi first, then lo).
    localparam int RET_PC_WORDS = 2;

    // Vector table: each entry is two words, hi at base, lo at base+1.
    localparam logic [10:0] VEC_BASE0_DEF = 11'd0;
    localparam logic [10:0] VEC_BASE1_DEF = 11'd2;

    // Sequencer states.
    //   state      | meaning
    //   ST_IDLE    | cpu owns memory port, waiting for pending + boundary
    //   ST_PUSH_HI | write retPc[31:16] to sp
    //   ST_PUSH_LO | write retPc[15:0] to sp-1
    //   ST_VEC_HI  | read vector hi word at base
    //   ST_VEC_LO  | read vector lo word at base+1
    //   ST_LOAD    | one-cycle pcLoad / spLoad / intAck
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_PUSH_HI = 3'd1;
    localparam state_t ST_PUSH_LO = 3'd2;
    localparam state_t ST_VEC_HI  = 3'd3;
    localparam state_t ST_VEC_LO  = 3'd4;
    localparam state_t ST_LOAD    = 3'd5;

    // Stack pointer arithmetic wraps modulo 2048 through the 11-bit width.
    function automatic logic [10:0] sp_minus(input logic [10:0] sp, input logic [10:0] n);
        return sp - n;
    endfunction

endpackage

// File: rtl/int_sequencer_if.sv
// Processor-side signal bundle of the interrupt sequencer.
// master: the sequencer itself; slave: the cpu / memory environment.
interface int_sequencer_if;
    logic [1:0]  interruptSignal;
    logic        instrBoundary;
    logic [31:0] retPc;
    logic [10:0] spIn;
    logic        cpuMemRead;
    logic        cpuMemWrite;
    logic [10:0] cpuAddr;
    logic [15:0] cpuWrData;
    logic [15:0] memRdData;
    logic        memRead;
    logic        memWrite;
    logic [10:0] memAddr;
    logic [15:0] memWrData;
    logic        stall;
    logic        pcLoad;
    logic [31:0] pcNew;
    logic        spLoad;
    logic [10:0] spNew;
    logic [1:0]  intAck;

    modport master (
        input  interruptSignal, instrBoundary, retPc, spIn,
               cpuMemRead, cpuMemWrite, cpuAddr, cpuWrData, memRdData,
        output memRead, memWrite, memAddr, memWrData,
               stall, pcLoad, pcNew, spLoad, spNew, intAck
    );

    modport slave (
        output interruptSignal, instrBoundary, retPc, spIn,
               cpuMemRead, cpuMemWrite, cpuAddr, cpuWrData, memRdData,
        input  memRead, memWrite, memAddr, memWrData,
               stall, pcLoad, pcNew, spLoad, spNew, intAck
    );
endinterface

// File: rtl/int_pending.sv
// Rising-edge detect and pending latch for the two interrupt lines,
// with a priority-encoded one-hot select (INT0 outranks INT1).
module int_pending (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] irq,
    input  logic [1:0] clr,
    output logic       any_pending,
    output logic [1:0] sel
);
    logic [1:0] prev_q, prev_d;
    logic [1:0] pend_q, pend_d;

    // A new edge outranks a same-cycle clear so no interrupt is dropped.
    always_comb begin
        prev_d = irq;
        pend_d = (pend_q & ~clr) | (irq & ~prev_q);
    end

    // Edge history and pending flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    // Fixed priority select of the line to service next.
    always_comb begin
        any_pending = |pend_q;
        if (pend_q[0])      sel = 2'b01;
        else if (pend_q[1]) sel = 2'b10;
        else                sel = 2'b00;
    end
endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry sequencer: pushes the return PC, fetches the ISR vector,
// then loads PC/SP and acknowledges the serviced line. The cpu is stalled
// for the whole sequence and owns the memory port only while idle.
module int_sequencer
    import int_sequencer_pkg::*;
#(
    parameter logic [10:0] VEC_BASE0 = VEC_BASE0_DEF,
    parameter logic [10:0] VEC_BASE1 = VEC_BASE1_DEF
) (
    input  logic           clk,
    input  logic           reset,
    int_sequencer_if.master bus
);
    state_t      state_q, state_d;
    logic [1:0]  line_q, line_d;
    logic [10:0] sp_q, sp_d;
    logic [31:0] ret_q, ret_d;
    logic [31:0] vec_q, vec_d;

    logic [1:0]  clr;
    logic        any_pend;
    logic [1:0]  sel;
    logic [10:0] base;

    logic        mem_read, mem_write, stall, pc_load, sp_load;
    logic [10:0] mem_addr, sp_new;
    logic [15:0] mem_wr_data;
    logic [31:0] pc_new;
    logic [1:0]  int_ack;

    int_pending u_pending (
        .clk         (clk),
        .reset       (reset),
        .irq         (bus.interruptSignal),
        .clr         (clr),
        .any_pending (any_pend),
        .sel         (sel)
    );

    // Next-state logic; line, sp and return PC are captured on leaving idle.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        sp_d    = sp_q;
        ret_d   = ret_q;
        vec_d   = vec_q;
        clr     = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (any_pend && bus.instrBoundary) begin
                    state_d = ST_PUSH_HI;
                    line_d  = sel;
                    sp_d    = bus.spIn;
                    ret_d   = bus.retPc;
                end
            end
            ST_PUSH_HI: state_d = ST_PUSH_LO;
            ST_PUSH_LO: state_d = ST_VEC_HI;
            ST_VEC_HI: begin
                vec_d[31:16] = bus.memRdData;
                state_d      = ST_VEC_LO;
            end
            ST_VEC_LO: begin
                vec_d[15:0] = bus.memRdData;
                state_d     = ST_LOAD;
            end
            ST_LOAD: begin
                clr     = line_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and service context registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            sp_q    <= '0;
            ret_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            sp_q    <= sp_d;
            ret_q   <= ret_d;
            vec_q   <= vec_d;
        end
    end

    // Output decode; idle passes cpu requests through, write wins a read/write clash.
    always_comb begin
        base        = line_q[0] ? VEC_BASE0 : VEC_BASE1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = bus.cpuAddr;
        mem_wr_data = bus.cpuWrData;
        stall       = 1'b1;
        pc_load     = 1'b0;
        sp_load     = 1'b0;
        pc_new      = '0;
        sp_new      = '0;
        int_ack     = 2'b00;
        case (state_q)
            ST_IDLE: begin
                stall     = 1'b0;
                mem_write = bus.cpuMemWrite;
                mem_read  = bus.cpuMemRead & ~bus.cpuMemWrite;
            end
            ST_PUSH_HI: begin
                mem_write   = 1'b1;
                mem_addr    = sp_q;
                mem_wr_data = ret_q[31:16];
            end
            ST_PUSH_LO: begin
                mem_write   = 1'b1;
                mem_addr    = sp_minus(sp_q, 11'd1);
                mem_wr_data = ret_q[15:0];
            end
            ST_VEC_HI: begin
                mem_read = 1'b1;
                mem_addr = base;
            end
            ST_VEC_LO: begin
                mem_read = 1'b1;
                mem_addr = base + 11'd1;
            end
            ST_LOAD: begin
                pc_load = 1'b1;
                sp_load = 1'b1;
                pc_new  = vec_q;
                sp_new  = sp_minus(sp_q, 11'(RET_PC_WORDS));
                int_ack = line_q;
            end
            default: stall = 1'b0;
        endcase
        // Nothing reaches memory or the cpu while reset is held.
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            stall     = 1'b0;
            pc_load   = 1'b0;
            sp_load   = 1'b0;
            pc_new    = '0;
            sp_new    = '0;
            int_ack   = 2'b00;
        end
    end

    assign bus.memRead   = mem_read;
    assign bus.memWrite  = mem_write;
    assign bus.memAddr   = mem_addr;
    assign bus.memWrData = mem_wr_data;
    assign bus.stall     = stall;
    assign bus.pcLoad    = pc_load;
    assign bus.pcNew     = pc_new;
    assign bus.spLoad    = sp_load;
    assign bus.spNew     = sp_new;
    assign bus.intAck    = int_ack;
endmodule

// File: tb/tb_int_sequencer.sv
// Testbench for int_sequencer: vector table of single services, hand-written
// multi-cycle sequences, then randomized traffic against a timeline model.
module tb_int_sequencer;
    localparam logic [31:0] PC0 = 32'h0002_0300;
    localparam logic [31:0] PC1 = 32'h0004_0500;
    localparam int NRAND = 2000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    int_sequencer_if bus();
    logic [15:0] mem [2048];

    int_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Vector table words are read-only; everything else is ordinary RAM.
    function automatic logic [15:0] vec_word(input logic [10:0] a);
        case (a)
            11'd0:   return 16'h0002;
            11'd1:   return 16'h0300;
            11'd2:   return 16'h0004;
            11'd3:   return 16'h0500;
            default: return 16'h0000;
        endcase
    endfunction

    assign bus.memRdData = (bus.memAddr < 11'd4) ? vec_word(bus.memAddr) : mem[bus.memAddr];

    always @(posedge clk) begin
        if (bus.memWrite && !reset) mem[bus.memAddr] <= bus.memWrData;
    end

    typedef struct {
        logic [1:0]  irq;
        logic [10:0] sp;
        logic [31:0] ret;
        logic [10:0] a0;
        logic [15:0] d0;
        logic [10:0] a1;
        logic [15:0] d1;
        logic [31:0] pc;
        logic [10:0] spn;
        logic [1:0]  ack;
    } svc_vec_t;

    logic [31:0] wr_a[$], wr_d[$], ld_pc[$], ld_sp[$], ld_ack[$], ld_idx[$];
    int first_stall, ack_cnt, rw_both;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] qa(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_DEAD;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Records memory writes, loads and acks for n cycles, sampling mid-cycle.
    task automatic observe(input int n);
        wr_a.delete(); wr_d.delete();
        ld_pc.delete(); ld_sp.delete(); ld_ack.delete(); ld_idx.delete();
        first_stall = -1;
        ack_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.memRead && bus.memWrite) rw_both++;
            if (bus.memWrite) begin
                wr_a.push_back(32'(bus.memAddr));
                wr_d.push_back(32'(bus.memWrData));
            end
            if (bus.stall && first_stall < 0) first_stall = i;
            if (bus.intAck != 2'b00) ack_cnt++;
            if (bus.pcLoad) begin
                ld_pc.push_back(bus.pcNew);
                ld_sp.push_back(32'(bus.spNew));
                ld_ack.push_back(32'(bus.intAck));
                ld_idx.push_back(32'(i));
            end
        end
        step();
    endtask

    initial begin
        svc_vec_t tbl[4];
        logic [1:0]  irq_r, pend, prev, m_line;
        logic [10:0] m_sp, m_base;
        logic [31:0] m_ret;
        int idle_from, start_c, clr_at, off, sel;

        tbl[0] = '{2'b01, 11'd100,  32'h0001_0040, 11'd100,  16'h0001, 11'd99,   16'h0040, PC0, 11'd98,   2'b01};
        tbl[1] = '{2'b10, 11'd0,    32'hDEAD_BEEF, 11'd0,    16'hDEAD, 11'd2047, 16'hBEEF, PC1, 11'd2046, 2'b10};
        tbl[2] = '{2'b10, 11'd1,    32'h1234_5678, 11'd1,    16'h1234, 11'd0,    16'h5678, PC1, 11'd2047, 2'b10};
        tbl[3] = '{2'b01, 11'd2047, 32'hCAFE_0001, 11'd2047, 16'hCAFE, 11'd2046, 16'h0001, PC0, 11'd2045, 2'b01};
        rw_both = 0;

        // Reset state, with a cpu write request present that must not leak out.
        reset = 1'b1;
        bus.interruptSignal = 2'b00;
        bus.instrBoundary = 1'b0;
        bus.retPc = 32'h0;
        bus.spIn = 11'd0;
        bus.cpuMemRead = 1'b0;
        bus.cpuMemWrite = 1'b1;
        bus.cpuAddr = 11'd5;
        bus.cpuWrData = 16'h1234;
        step(); step();
        @(negedge clk);
        check("rst_stall",   32'(bus.stall), 32'd0);
        check("rst_pcload",  32'(bus.pcLoad), 32'd0);
        check("rst_spload",  32'(bus.spLoad), 32'd0);
        check("rst_intack",  32'(bus.intAck), 32'd0);
        check("rst_memread", 32'(bus.memRead), 32'd0);
        check("rst_memwr",   32'(bus.memWrite), 32'd0);
        check("rst_pcnew",   bus.pcNew, 32'd0);
        check("rst_spnew",   32'(bus.spNew), 32'd0);
        step();
        reset = 1'b0;
        bus.cpuMemWrite = 1'b0;
        idle(2);

        // Single-service vector table.
        for (int r = 0; r < 4; r++) begin
            bus.interruptSignal = tbl[r].irq;
            bus.spIn = tbl[r].sp;
            bus.retPc = tbl[r].ret;
            bus.instrBoundary = 1'b1;
            observe(12);
            bus.interruptSignal = 2'b00;
            idle(3);
            check($sformatf("row%0d_nwr", r),  32'(wr_a.size()), 32'd2);
            check($sformatf("row%0d_a0", r),   qa(wr_a, 0), 32'(tbl[r].a0));
            check($sformatf("row%0d_d0", r),   qa(wr_d, 0), 32'(tbl[r].d0));
            check($sformatf("row%0d_a1", r),   qa(wr_a, 1), 32'(tbl[r].a1));
            check($sformatf("row%0d_d1", r),   qa(wr_d, 1), 32'(tbl[r].d1));
            check($sformatf("row%0d_nld", r),  32'(ld_pc.size()), 32'd1);
            check($sformatf("row%0d_pc", r),   qa(ld_pc, 0), tbl[r].pc);
            check($sformatf("row%0d_sp", r),   qa(ld_sp, 0), 32'(tbl[r].spn));
            check($sformatf("row%0d_ack", r),  qa(ld_ack, 0), 32'(tbl[r].ack));
            check($sformatf("row%0d_lat", r),  qa(ld_idx, 0) - 32'(first_stall) + 32'd1, 32'd5);
            check($sformatf("row%0d_nack", r), 32'(ack_cnt), 32'd1);
        end

        // Simultaneous edges: INT0 first, INT1 immediately after.
        bus.spIn = 11'd500;
        bus.interruptSignal = 2'b11;
        observe(20);
        bus.interruptSignal = 2'b00;
        idle(3);
        check("both_nld",  32'(ld_pc.size()), 32'd2);
        check("both_ack0", qa(ld_ack, 0), 32'h1);
        check("both_ack1", qa(ld_ack, 1), 32'h2);
        check("both_pc0",  qa(ld_pc, 0), PC0);
        check("both_pc1",  qa(ld_pc, 1), PC1);
        check("both_gap",  qa(ld_idx, 1) - qa(ld_idx, 0), 32'd6);
        check("both_nwr",  32'(wr_a.size()), 32'd4);

        // INT0 edge during INT1 service waits its turn.
        bus.interruptSignal = 2'b10;
        idle(3);
        bus.interruptSignal = 2'b11;
        observe(16);
        bus.interruptSignal = 2'b00;
        idle(3);
        check("nopre_nld",  32'(ld_pc.size()), 32'd2);
        check("nopre_ack0", qa(ld_ack, 0), 32'h2);
        check("nopre_ack1", qa(ld_ack, 1), 32'h1);
        check("nopre_pc1",  qa(ld_pc, 1), PC0);
        check("nopre_gap",  qa(ld_idx, 1) - qa(ld_idx, 0), 32'd6);

        // INT1 pending while the cpu is not at a boundary: cpu keeps the port.
        bus.instrBoundary = 1'b0;
        bus.interruptSignal = 2'b10;
        step();
        bus.interruptSignal = 2'b00;
        for (int i = 0; i < 10; i++) begin
            bus.cpuMemWrite = 1'b1;
            bus.cpuAddr = 11'(200 + i);
            bus.cpuWrData = 16'(16'h1000 + i);
            @(negedge clk);
            check($sformatf("wait%0d_stall", i), 32'(bus.stall), 32'd0);
            check($sformatf("wait%0d_we", i),    32'(bus.memWrite), 32'd1);
            check($sformatf("wait%0d_addr", i),  32'(bus.memAddr), 32'(200 + i));
            check($sformatf("wait%0d_data", i),  32'(bus.memWrData), 32'(16'h1000 + i));
            step();
        end
        bus.cpuMemWrite = 1'b0;
        bus.instrBoundary = 1'b1;
        observe(10);
        check("wait_first_stall", 32'(first_stall), 32'd1);
        check("wait_ack",         qa(ld_ack, 0), 32'h2);
        check("wait_ld_idx",      qa(ld_idx, 0), 32'd5);
        idle(2);

        // Level held high: a single service only.
        bus.interruptSignal = 2'b01;
        observe(25);
        bus.interruptSignal = 2'b00;
        idle(3);
        check("level_nld",  32'(ld_pc.size()), 32'd1);
        check("level_nack", 32'(ack_cnt), 32'd1);

        // Reset during PUSH_LO abandons the service.
        bus.spIn = 11'd300;
        bus.retPc = 32'hABCD_1234;
        bus.interruptSignal = 2'b01;
        step();
        bus.interruptSignal = 2'b00;
        step();
        @(negedge clk);
        check("rstsvc_pushhi_we",   32'(bus.memWrite), 32'd1);
        check("rstsvc_pushhi_addr", 32'(bus.memAddr), 32'd300);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        observe(15);
        check("rstsvc_nwr",   32'(wr_a.size()), 32'd0);
        check("rstsvc_nld",   32'(ld_pc.size()), 32'd0);
        check("rstsvc_stall", 32'(first_stall), 32'hFFFF_FFFF);
        check("rw_exclusive", 32'(rw_both), 32'd0);

        // Randomized traffic against a service-timeline model.
        reset = 1'b1;
        bus.interruptSignal = 2'b00;
        step(); step();
        reset = 1'b0;
        irq_r = 2'b00; pend = 2'b00; prev = 2'b00; m_line = 2'b00;
        m_sp = '0; m_ret = '0;
        idle_from = 0; start_c = -100; clr_at = -1;
        for (int j = 0; j < NRAND; j++) begin
            for (int b = 0; b < 2; b++) if ($urandom_range(0, 7) == 0) irq_r[b] = ~irq_r[b];
            bus.interruptSignal = irq_r;
            bus.instrBoundary = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 3);
            bus.cpuMemRead = (sel == 1);
            bus.cpuMemWrite = (sel == 2);
            bus.cpuAddr = 11'($urandom_range(16, 2047));
            bus.cpuWrData = 16'($urandom);
            bus.spIn = 11'($urandom_range(100, 2000));
            bus.retPc = $urandom;
            @(negedge clk);
            if (j < idle_from) begin
                off = j - start_c;
                m_base = m_line[0] ? 11'd0 : 11'd2;
                check("rnd_stall", 32'(bus.stall), 32'd1);
                check("rnd_we", 32'(bus.memWrite), (off <= 2) ? 32'd1 : 32'd0);
                check("rnd_re", 32'(bus.memRead), (off == 3 || off == 4) ? 32'd1 : 32'd0);
                check("rnd_pcload", 32'(bus.pcLoad), (off == 5) ? 32'd1 : 32'd0);
                if (off == 1) begin
                    check("rnd_push_hi_addr", 32'(bus.memAddr), 32'(m_sp));
                    check("rnd_push_hi_data", 32'(bus.memWrData), 32'(m_ret[31:16]));
                end else if (off == 2) begin
                    check("rnd_push_lo_addr", 32'(bus.memAddr), 32'(11'(m_sp - 11'd1)));
                    check("rnd_push_lo_data", 32'(bus.memWrData), 32'(m_ret[15:0]));
                end else if (off == 3 || off == 4) begin
                    check("rnd_vec_addr", 32'(bus.memAddr), 32'(11'(m_base + 11'(off - 3))));
                end else begin
                    check("rnd_spload", 32'(bus.spLoad), 32'd1);
                    check("rnd_pcnew", bus.pcNew, m_line[0] ? PC0 : PC1);
                    check("rnd_spnew", 32'(bus.spNew), 32'(11'(m_sp - 11'd2)));
                    check("rnd_ack", 32'(bus.intAck), 32'(m_line));
                end
            end else begin
                check("rnd_idle_stall", 32'(bus.stall), 32'd0);
                check("rnd_idle_we", 32'(bus.memWrite), 32'(bus.cpuMemWrite));
                check("rnd_idle_re", 32'(bus.memRead), 32'(bus.cpuMemRead));
                if (bus.cpuMemWrite || bus.cpuMemRead)
                    check("rnd_idle_addr", 32'(bus.memAddr), 32'(bus.cpuAddr));
                if (bus.cpuMemWrite)
                    check("rnd_idle_data", 32'(bus.memWrData), 32'(bus.cpuWrData));
                check("rnd_idle_pcload", 32'(bus.pcLoad), 32'd0);
                check("rnd_idle_ack", 32'(bus.intAck), 32'd0);
            end
            if (j >= idle_from && pend != 2'b00 && bus.instrBoundary) begin
                start_c = j;
                idle_from = j + 6;
                clr_at = j + 5;
                m_line = pend[0] ? 2'b01 : 2'b10;
                m_sp = bus.spIn;
                m_ret = bus.retPc;
            end
            if (j == clr_at) pend = pend & ~m_line;
            pend = pend | (irq_r & ~prev);
            prev = irq_r;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
